// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// width helper used to size the bit counter.
package serial_adder_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Number of bits needed to hold values 0..value-1 (minimum 0).
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_adder_fulladder.sv
// One-bit full-adder cell shared across the team's datapaths.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands stream LSB-first through one full
// adder with a registered carry; the result is rebuilt in a shift register.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] result_sh;
  logic [WIDTH-1:0] result_next;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic             fa_sum;
  logic             fa_cout;

  fulladder u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  // Written as shift-then-insert so WIDTH=1 needs no special slice.
  always_comb begin
    result_next            = result_sh >> 1;
    result_next[WIDTH-1]   = fa_sum;
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      result_sh <= '0;
      carry     <= 1'b0;
      count     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            count <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          result_sh <= result_next;
          carry     <= fa_cout;
          a_sh      <= a_sh >> 1;
          b_sh      <= b_sh >> 1;
          count     <= count + CNT_W'(1);
          // The final bit is folded straight into the held outputs.
          if (count == LAST_BIT) begin
            sum   <= result_next;
            cout  <= fa_cout;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1 against
// plain integer addition.
module tb_serial_adder;

  logic clk;
  logic rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int errors = 0;
  int checks = 0;
  logic       mon_en = 1'b0;
  logic [8:0] prev8;
  logic [1:0] prev1;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Held results may only move on the cycle done is high.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      checks++;
      if (!done8 && {cout8, sum8} !== prev8) begin
        errors++;
        $display("[TB] FAIL hold8: got %h expected %h", {cout8, sum8}, prev8);
      end
      checks++;
      if (!done1 && {cout1, sum1} !== prev1) begin
        errors++;
        $display("[TB] FAIL hold1: got %h expected %h", {cout1, sum1}, prev1);
      end
    end
    prev8 = {cout8, sum8};
    prev1 = {cout1, sum1};
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_op8(input logic [7:0] x, input logic [7:0] y, input logic c,
                        input int glitch_at, output logic [7:0] s, output logic co,
                        output int lat, output int busy_cycles);
    int k;
    @(negedge clk);
    a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    k = 0;
    busy_cycles = 0;
    while (!done8 && k < 40) begin
      if (busy8) busy_cycles++;
      if (k == glitch_at) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start8 = 1'b0;
    s = sum8; co = cout8; lat = k;
  endtask

  task automatic do_op1(input logic x, input logic y, input logic c,
                        output logic s, output logic co, output int lat);
    int k;
    @(negedge clk);
    a1 = x; b1 = y; cin1 = c; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    k = 0;
    while (!done1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    s = sum1; co = cout1; lat = k;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset8: got %h expected 000", {busy8, done8, cout8, sum8});
    end
    checks++;
    if ({busy1, done1, cout1, sum1} !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset1: got %h expected 0", {busy1, done1, cout1, sum1});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy8, done8);
    end
  endtask

  task automatic test_basic();
    logic [7:0] xs[3] = '{8'h3C, 8'hFF, 8'hFF};
    logic [7:0] ys[3] = '{8'h5A, 8'h01, 8'hFF};
    logic       cs[3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] es[3] = '{9'h096, 9'h100, 9'h1FF};
    logic [7:0] s;
    logic       co;
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      do_op8(xs[i], ys[i], cs[i], -1, s, co, lat, bc);
      checks++;
      if ({co, s} !== es[i]) begin
        errors++;
        $display("[TB] FAIL basic_sum%0d: got %h expected %h", i, {co, s}, es[i]);
      end
      checks++;
      if (lat != 8 || bc != 8) begin
        errors++;
        $display("[TB] FAIL basic_timing%0d: lat=%0d busy=%0d expected 8 8", i, lat, bc);
      end
      @(negedge clk);
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL basic_pulse%0d: done=%b busy=%b expected 0 0", i, done8, busy8);
      end
    end
  endtask

  task automatic test_width1();
    logic s, co;
    logic [1:0] expv;
    int lat;
    for (int i = 0; i < 8; i++) begin
      do_op1(i[2], i[1], i[0], s, co, lat);
      expv = 2'(int'(i[2]) + int'(i[1]) + int'(i[0]));
      checks++;
      if ({co, s} !== expv || lat != 1) begin
        errors++;
        $display("[TB] FAIL width1_%0d: got %b lat=%0d expected %b lat=1", i, {co, s}, lat, expv);
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [7:0] s;
    logic       co;
    int lat, bc;
    do_op8(8'h10, 8'h20, 1'b0, 3, s, co, lat, bc);
    checks++;
    if ({co, s} !== 9'h030 || lat != 8) begin
      errors++;
      $display("[TB] FAIL ignored_start: got %h lat=%0d expected 030 lat=8", {co, s}, lat);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignored_queue: done=%b busy=%b expected 0 0", done8, busy8);
    end
  endtask

  task automatic test_midop_reset();
    logic [7:0] s;
    logic       co;
    int lat, bc;
    int saw_done;
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL midop_reset8: got %h expected 000", {busy8, done8, cout8, sum8});
    end
    checks++;
    if ({busy1, done1, cout1, sum1} !== 4'd0) begin
      errors++;
      $display("[TB] FAIL midop_reset1: got %h expected 0", {busy1, done1, cout1, sum1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8 || busy8) saw_done++;
    end
    checks++;
    if (saw_done != 0) begin
      errors++;
      $display("[TB] FAIL aborted_activity: got %0d active cycles expected 0", saw_done);
    end
    do_op8(8'h12, 8'h34, 1'b1, -1, s, co, lat, bc);
    checks++;
    if ({co, s} !== 9'h047 || lat != 8) begin
      errors++;
      $display("[TB] FAIL after_reset_op: got %h lat=%0d expected 047 lat=8", {co, s}, lat);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    int held_bad;
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    k = 0;
    while (!done8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sum8 !== 8'h96 || k != 8) begin
      errors++;
      $display("[TB] FAIL b2b_first: got %h k=%0d expected 96 k=8", sum8, k);
    end
    a8 = 8'h01; b8 = 8'h01;
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_no_idle: busy=%b expected 1", busy8);
    end
    k = 0;
    held_bad = 0;
    while (!done8 && k < 40) begin
      if (sum8 !== 8'h96 || cout8 !== 1'b0) held_bad++;
      @(negedge clk);
      k++;
    end
    checks++;
    if (held_bad != 0) begin
      errors++;
      $display("[TB] FAIL b2b_hold: got %0d changed cycles expected 0", held_bad);
    end
    checks++;
    if ({cout8, sum8} !== 9'h002 || k != 8) begin
      errors++;
      $display("[TB] FAIL b2b_second: got %h k=%0d expected 002 k=8", {cout8, sum8}, k);
    end
  endtask

  task automatic test_random();
    logic [7:0] x, y, s;
    logic       c, co, s1, co1;
    logic [8:0] expv;
    int lat, bc;
    mon_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
      expv = 9'(int'(x) + int'(y) + int'(c));
      do_op8(x, y, c, -1, s, co, lat, bc);
      checks++;
      if ({co, s} !== expv || lat != 8) begin
        errors++;
        $display("[TB] FAIL rand8: %h+%h+%b got %h lat=%0d expected %h lat=8",
                 x, y, c, {co, s}, lat, expv);
      end
    end
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom_range(1)); y = 8'($urandom_range(1)); c = 1'($urandom);
      expv = 9'(int'(x) + int'(y) + int'(c));
      do_op1(x[0], y[0], c, s1, co1, lat);
      checks++;
      if ({7'd0, co1, s1} !== expv || lat != 1) begin
        errors++;
        $display("[TB] FAIL rand1: %b+%b+%b got %b%b lat=%0d expected %h lat=1",
                 x[0], y[0], c, co1, s1, lat, expv);
      end
    end
    @(negedge clk);
    mon_en = 1'b0;
  endtask

  initial begin
    $display("[TB] starting serial_adder bench");
    test_reset();
    test_basic();
    test_width1();
    test_ignored_start();
    test_midop_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
